// File: rtl/hdmi_pkg.sv
// Shared HDMI data-island packet type codes and InfoFrame sequencer encoding.
package hdmi_pkg;

  typedef enum logic [2:0] {
    PKT_NULL  = 3'd0,
    PKT_AUDIO = 3'd1,
    PKT_ACR   = 3'd2,
    PKT_AVI   = 3'd3,
    PKT_SPD   = 3'd4,
    PKT_AIF   = 3'd5
  } pkt_type_e;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_AVI  = 2'd1,
    IF_SPD  = 2'd2,
    IF_AUD  = 2'd3
  } if_state_e;

  function automatic pkt_type_e if_pkt(input if_state_e st);
    pkt_type_e p;
    case (st)
      IF_AVI:  p = PKT_AVI;
      IF_SPD:  p = PKT_SPD;
      IF_AUD:  p = PKT_AIF;
      default: p = PKT_NULL;
    endcase
    return p;
  endfunction

  function automatic if_state_e if_next(input if_state_e st, input logic en_spd);
    if_state_e n;
    case (st)
      IF_AVI:  n = en_spd ? IF_SPD : IF_AUD;
      IF_SPD:  n = IF_AUD;
      IF_AUD:  n = IF_IDLE;
      default: n = IF_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/hdmi_infoframe_seq.sv
// InfoFrame sequencer: walks AVI -> SPD -> audio InfoFrame once per video field.
module hdmi_infoframe_seq
  import hdmi_pkg::*;
#(
  parameter bit ENABLE_SPD = 1'b1
) (
  input  logic      clk_pixel,
  input  logic      reset,
  input  logic      video_field_end,
  input  logic      if_grant,
  output if_state_e if_state,
  output logic      overrun
);

  if_state_e state_r;
  if_state_e state_nxt_s;

  // A field end restarts the sequence before any same-cycle arbitration looks at it.
  assign if_state = video_field_end ? IF_AVI : state_r;
  assign overrun  = video_field_end && (state_r != IF_IDLE);

  // Next state: advance only when the current InfoFrame wins its slot.
  always_comb begin
    state_nxt_s = if_state;
    if (if_grant) begin
      state_nxt_s = if_next(if_state, ENABLE_SPD);
    end else begin
      state_nxt_s = if_state;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_r <= IF_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

endmodule

// File: rtl/hdmi_packet_scheduler.sv
// Data-island slot arbiter: audio > ACR > InfoFrame > null, with an audio burst limit.
module hdmi_packet_scheduler
  import hdmi_pkg::*;
#(
  parameter int AUDIO_BURST_MAX = 3,
  parameter bit ENABLE_SPD      = 1'b1
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic       packet_enable,
  input  logic       video_field_end,
  input  logic       audio_req,
  input  logic       acr_tick,
  output logic       grant_valid,
  output logic [2:0] grant_type,
  output logic       audio_ack,
  output logic       if_overrun
);

  localparam int BURST_W_RAW = $clog2(AUDIO_BURST_MAX + 1);
  localparam int BURST_W     = (BURST_W_RAW < 2) ? 2 : BURST_W_RAW;
  localparam logic [BURST_W-1:0] BURST_MAX_C = BURST_W'(AUDIO_BURST_MAX);

  logic               acr_pending_r;
  logic [BURST_W-1:0] burst_r;
  if_state_e          if_state_s;
  logic               overrun_s;
  logic               if_grant_s;
  logic               if_pend_s;
  logic               other_pend_s;
  logic               burst_cap_s;
  pkt_type_e          sel_s;

  hdmi_infoframe_seq #(
    .ENABLE_SPD(ENABLE_SPD)
  ) u_if_seq (
    .clk_pixel      (clk_pixel),
    .reset          (reset),
    .video_field_end(video_field_end),
    .if_grant       (if_grant_s),
    .if_state       (if_state_s),
    .overrun        (overrun_s)
  );

  assign if_pend_s    = (if_state_s != IF_IDLE);
  assign other_pend_s = acr_pending_r || if_pend_s;
  assign burst_cap_s  = (burst_r == BURST_MAX_C);
  assign if_grant_s   = packet_enable &&
                        ((sel_s == PKT_AVI) || (sel_s == PKT_SPD) || (sel_s == PKT_AIF));

  // Slot priority; a full audio burst yields one slot to whatever else is waiting.
  always_comb begin
    sel_s = PKT_NULL;
    if (audio_req && !(burst_cap_s && other_pend_s)) begin
      sel_s = PKT_AUDIO;
    end else if (acr_pending_r) begin
      sel_s = PKT_ACR;
    end else if (if_pend_s) begin
      sel_s = if_pkt(if_state_s);
    end else begin
      sel_s = PKT_NULL;
    end
  end

  // Registered grant outputs, ACR pending flag and saturating audio burst counter.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      grant_valid   <= 1'b0;
      grant_type    <= 3'd0;
      audio_ack     <= 1'b0;
      if_overrun    <= 1'b0;
      acr_pending_r <= 1'b0;
      burst_r       <= '0;
    end else begin
      grant_valid <= packet_enable;
      audio_ack   <= packet_enable && (sel_s == PKT_AUDIO);
      if_overrun  <= overrun_s;
      if (packet_enable) begin
        grant_type <= sel_s;
        if (sel_s == PKT_AUDIO) begin
          if (!burst_cap_s) begin
            burst_r <= burst_r + BURST_W'(1);
          end
        end else begin
          burst_r <= '0;
        end
      end
      // A new tick outranks a same-cycle ACR grant so no request is lost.
      if (acr_tick) begin
        acr_pending_r <= 1'b1;
      end else if (packet_enable && (sel_s == PKT_ACR)) begin
        acr_pending_r <= 1'b0;
      end
    end
  end

endmodule
